// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - 3-stage IEEE-754 single multiplier, FTZ, RNE, tagged; FMUL_SPECIAL_EN adds NaN/Inf handling
module fmul_pipe #(
  parameter int TAGW   = 4,
  parameter int NSTAGE = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     x1,
  input  logic [31:0]     x2,
  input  logic            in_valid,
  input  logic [TAGW-1:0] in_tag,
  input  logic            stall,
  output logic [31:0]     y,
  output logic            ovf,
  output logic            out_valid,
  output logic [TAGW-1:0] out_tag
);

  if (NSTAGE != 3) begin : g_nstage_check
    $error("fmul_pipe: NSTAGE must be 3");
  end

  // Stage 1: unpack, sign, exponent sum, two 24x12 partial products
  logic [7:0]  e1, e2;
  logic [23:0] ma, mb;
  logic [35:0] pp_lo_c, pp_hi_c;
  logic [9:0]  esum_c;
  logic        zero_c;

  assign e1      = x1[30:23];
  assign e2      = x2[30:23];
  assign ma      = {1'b1, x1[22:0]};
  assign mb      = {1'b1, x2[22:0]};
  assign pp_lo_c = {12'b0, ma} * {24'b0, mb[11:0]};
  assign pp_hi_c = {12'b0, ma} * {24'b0, mb[23:12]};
  assign esum_c  = {2'b0, e1} + {2'b0, e2};
  assign zero_c  = (e1 == 8'd0) || (e2 == 8'd0);

  logic            s1_valid, s1_sign, s1_zero;
  logic [TAGW-1:0] s1_tag;
  logic [9:0]      s1_esum;
  logic [35:0]     s1_pp_lo, s1_pp_hi;

`ifdef FMUL_SPECIAL_EN
  logic nan_c, inf_c;
  logic s1_nan, s1_inf, s2_nan, s2_inf;

  assign nan_c = ((e1 == 8'hFF) && (x1[22:0] != 23'd0)) ||
                 ((e2 == 8'hFF) && (x2[22:0] != 23'd0));
  assign inf_c = ((e1 == 8'hFF) && (x1[22:0] == 23'd0)) ||
                 ((e2 == 8'hFF) && (x2[22:0] == 23'd0));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_esum  <= '0;
      s1_pp_lo <= '0;
      s1_pp_hi <= '0;
`ifdef FMUL_SPECIAL_EN
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
`endif
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
      s1_sign  <= x1[31] ^ x2[31];
      s1_zero  <= zero_c;
      s1_esum  <= esum_c;
      s1_pp_lo <= pp_lo_c;
      s1_pp_hi <= pp_hi_c;
`ifdef FMUL_SPECIAL_EN
      s1_nan   <= nan_c;
      s1_inf   <= inf_c;
`endif
    end
  end

  // Stage 2: sum partial products and normalise to a 1.23 window
  logic [47:0]       p_c;
  logic [22:0]       mant_c;
  logic              guard_c, sticky_c;
  logic signed [9:0] exp_c;

  assign p_c = {12'b0, s1_pp_lo} + {s1_pp_hi, 12'b0};

  always_comb begin
    mant_c   = p_c[45:23];
    guard_c  = p_c[22];
    sticky_c = |p_c[21:0];
    exp_c    = $signed(s1_esum - 10'd127);
    if (p_c[47]) begin
      mant_c   = p_c[46:24];
      guard_c  = p_c[23];
      sticky_c = |p_c[22:0];
      exp_c    = $signed(s1_esum - 10'd126);
    end
  end

  logic              s2_valid, s2_sign, s2_zero, s2_guard, s2_sticky;
  logic [TAGW-1:0]   s2_tag;
  logic [22:0]       s2_mant;
  logic signed [9:0] s2_exp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_mant   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_exp    <= '0;
`ifdef FMUL_SPECIAL_EN
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
`endif
    end else if (!stall) begin
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_mant   <= mant_c;
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
      s2_exp    <= exp_c;
`ifdef FMUL_SPECIAL_EN
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
`endif
    end
  end

  // Stage 3: round to nearest even, then zero / overflow / flush selection
  logic              inc_c;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [31:0]       y_c;
  logic              ovf_c;

  assign inc_c  = s2_guard & (s2_sticky | s2_mant[0]);
  assign mant_r = {1'b0, s2_mant} + {23'b0, inc_c};
  assign exp_r  = s2_exp + (mant_r[23] ? 10'sd1 : 10'sd0);

  always_comb begin
    y_c   = {s2_sign, exp_r[7:0], mant_r[23] ? 23'd0 : mant_r[22:0]};
    ovf_c = 1'b0;
    if (s2_zero) begin
      y_c = {s2_sign, 31'b0};
    end else if (exp_r >= 10'sd255) begin
      y_c   = {s2_sign, 8'hFF, 23'b0};
      ovf_c = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      y_c = {s2_sign, 31'b0};
    end
`ifdef FMUL_SPECIAL_EN
    if (s2_nan || (s2_inf && s2_zero)) begin
      y_c   = 32'h7FC0_0000;
      ovf_c = 1'b0;
    end else if (s2_inf) begin
      y_c   = {s2_sign, 8'hFF, 23'b0};
      ovf_c = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      out_tag   <= s2_tag;
      y         <= y_c;
      ovf       <= ovf_c;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - directed vector bench for fmul_pipe
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] x1 = '0, x2 = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        stall = 1'b0;
  logic [31:0] y;
  logic        ovf, out_valid;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  fmul_pipe #(.TAGW(4), .NSTAGE(3)) dut (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid),
    .in_tag(in_tag), .stall(stall), .y(y), .ovf(ovf),
    .out_valid(out_valid), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ye, input logic oe);
    vecs[nv] = '{a, b, 4'(nv), ye, oe};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic [3:0] t);
    x1 = a; x2 = b; in_valid = v; in_tag = t;
  endtask

  task automatic chk_out(input string name, input logic [31:0] ye,
                         input logic oe, input logic [3:0] te);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_y"}, y, ye);
    chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, oe});
    chk({name, "_tag"}, {28'b0, out_tag}, {28'b0, te});
  endtask

  initial begin
    add(32'h3F800000, 32'h40000000, 32'h40000000, 1'b0);
    add(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0);
    add(32'h40400000, 32'hBF000000, 32'hBFC00000, 1'b0);
    add(32'h00000000, 32'h40490FDB, 32'h00000000, 1'b0);
    add(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0);
    add(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0);
    add(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 1'b0);  // tie, odd lsb: round up
    add(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0);  // tie, even lsb: hold
    add(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b0);  // mantissa carry-out
    add(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
    add(32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
    add(32'h00400000, 32'h40000000, 32'h00000000, 1'b0);
    add(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0);  // smallest normal survives
    add(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0);  // exp 0 flushes
    add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0);
    add(32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 1'b1);  // rounding pushes into overflow
    add(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0);
    add(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);
    add(32'hFF000000, 32'hC0000000, 32'h7F800000, 1'b1);
`ifdef FMUL_SPECIAL_EN
    add(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0);
    add(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0);
    add(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
`else
    add(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1);
    add(32'h7FC00000, 32'h3F800000, 32'h7F800000, 1'b1);
    add(32'h7F800000, 32'h00000000, 32'h00000000, 1'b0);
`endif

    // reset state
    #3;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_tag", {28'b0, out_tag}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // basic latency: accept edge plus two more edges
    drive(32'h3F800000, 32'h40000000, 1'b1, 4'd5);
    tick();
    drive('0, '0, 1'b0, 4'd0);
    chk("basic_lat1", {31'b0, out_valid}, 32'd0);
    tick();
    chk("basic_lat2", {31'b0, out_valid}, 32'd0);
    tick();
    chk_out("basic", 32'h40000000, 1'b0, 4'd5);
    tick();
    chk("basic_after", {31'b0, out_valid}, 32'd0);

    // back-to-back stream of the whole table
    for (int c = 0; c < nv + 2; c++) begin
      if (c < nv) drive(vecs[c].a, vecs[c].b, 1'b1, vecs[c].tag);
      else        drive('0, '0, 1'b0, 4'd0);
      tick();
      if (c >= 2) chk_out($sformatf("vec%0d", c - 2), vecs[c-2].y, vecs[c-2].ovf, vecs[c-2].tag);
    end
    tick();
    chk("stream_drain", {31'b0, out_valid}, 32'd0);
    tick();

    // stall: A,B,C accepted, two stalled edges with junk on the inputs, then D
    drive(vecs[1].a, vecs[1].b, 1'b1, 4'd8);  tick();
    drive(vecs[2].a, vecs[2].b, 1'b1, 4'd9);  tick();
    drive(vecs[4].a, vecs[4].b, 1'b1, 4'd10); tick();
    chk_out("stall_a0", vecs[1].y, vecs[1].ovf, 4'd8);
    stall = 1'b1;
    drive(32'h12345678, 32'h40000000, 1'b1, 4'd15);
    tick();
    chk_out("stall_a1", vecs[1].y, vecs[1].ovf, 4'd8);
    tick();
    chk_out("stall_a2", vecs[1].y, vecs[1].ovf, 4'd8);
    stall = 1'b0;
    drive(vecs[16].a, vecs[16].b, 1'b1, 4'd11); tick();
    drive('0, '0, 1'b0, 4'd0);
    chk_out("stall_b", vecs[2].y, vecs[2].ovf, 4'd9);
    tick();
    chk_out("stall_c", vecs[4].y, vecs[4].ovf, 4'd10);
    tick();
    chk_out("stall_d", vecs[16].y, vecs[16].ovf, 4'd11);
    tick();
    chk("stall_end1", {31'b0, out_valid}, 32'd0);
    tick();
    chk("stall_end2", {31'b0, out_valid}, 32'd0);

    // reset with three operations in flight
    drive(vecs[1].a, vecs[1].b, 1'b1, 4'd1); tick();
    drive(vecs[2].a, vecs[2].b, 1'b1, 4'd2); tick();
    drive(vecs[4].a, vecs[4].b, 1'b1, 4'd3); tick();
    drive('0, '0, 1'b0, 4'd0);
    chk_out("inflight", vecs[1].y, vecs[1].ovf, 4'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_y", y, 32'd0);
    chk("midrst_ovf", {31'b0, ovf}, 32'd0);
    chk("midrst_tag", {28'b0, out_tag}, 32'd0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("postrst_idle%0d", k), {31'b0, out_valid}, 32'd0);
    end
    drive(32'h3F800000, 32'h40000000, 1'b1, 4'd6);
    tick();
    drive('0, '0, 1'b0, 4'd0);
    tick();
    chk("postrst_lat2", {31'b0, out_valid}, 32'd0);
    tick();
    chk_out("postrst", 32'h40000000, 1'b0, 4'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
